// File: rtl/tx_frame_arb.sv
// rtl/tx_frame_arb.sv - frame-atomic round-robin arbiter feeding the uart1 TX FIFO
`timescale 1ns/1ps
module tx_frame_arb #(
  parameter logic [4:0]  AFULL_LVL = 5'd30,
  parameter logic [7:0]  MAX_FRAME = 8'd200,
  parameter logic [15:0] TIMEOUT   = 16'd11059
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [2:0]  req,
  input  logic [2:0]  vld,
  input  logic [2:0]  last,
  input  logic [7:0]  din0,
  input  logic [7:0]  din1,
  input  logic [7:0]  din2,
  output logic [2:0]  ack,
  output logic [2:0]  gnt,
  output logic        tx_fifo_wen,
  output logic [7:0]  tx_fifo_wdata,
  input  logic        tx_fifo_full,
  input  logic [4:0]  tx_fifo_usedw,
  output logic [15:0] frm_cnt,
  output logic        err_ovf,
  output logic        err_tmo
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t      state;
  logic [1:0]  rr_ptr;
  logic [1:0]  g_idx;
  logic [7:0]  byte_cnt;
  logic [15:0] tmo_cnt;

  logic        room;
  logic        g_vld;
  logic        g_last;
  logic        fire;
  logic [7:0]  g_din;
  logic [1:0]  nxt_idx;
  logic        nxt_any;
  logic [1:0]  cand;

  always_comb begin
    room   = !tx_fifo_full && (tx_fifo_usedw < AFULL_LVL);
    g_vld  = |(vld & gnt);
    g_last = |(last & gnt);
    // gnt is all-zero outside XFER, so ack needs no state term
    ack    = vld & gnt & {3{room}};
    fire   = (state == XFER) && g_vld && room;
    case (g_idx)
      2'd0:    g_din = din0;
      2'd1:    g_din = din1;
      default: g_din = din2;
    endcase
  end

  // scan req starting one past the last-granted index
  always_comb begin
    nxt_idx = 2'd0;
    nxt_any = 1'b0;
    cand    = rr_ptr;
    for (int k = 0; k < 3; k++) begin
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
      if (!nxt_any && req[cand]) begin
        nxt_any = 1'b1;
        nxt_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      rr_ptr        <= 2'd2;
      g_idx         <= 2'd0;
      gnt           <= 3'b000;
      byte_cnt      <= 8'd0;
      tmo_cnt       <= 16'd0;
      tx_fifo_wen   <= 1'b0;
      tx_fifo_wdata <= 8'd0;
      frm_cnt       <= 16'd0;
      err_ovf       <= 1'b0;
      err_tmo       <= 1'b0;
    end else begin
      tx_fifo_wen <= 1'b0;
      err_ovf     <= 1'b0;
      err_tmo     <= 1'b0;
      case (state)
        IDLE: begin
          if (ena && nxt_any) begin
            gnt      <= 3'b001 << nxt_idx;
            g_idx    <= nxt_idx;
            byte_cnt <= 8'd0;
            tmo_cnt  <= 16'd0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (fire) begin
            tx_fifo_wen   <= 1'b1;
            tx_fifo_wdata <= g_din;
            byte_cnt      <= byte_cnt + 8'd1;
            tmo_cnt       <= 16'd0;
            if (g_last) begin
              gnt     <= 3'b000;
              rr_ptr  <= g_idx;
              frm_cnt <= frm_cnt + 16'd1;
              state   <= IDLE;
            end else if (byte_cnt == MAX_FRAME - 8'd1) begin
              gnt     <= 3'b000;
              rr_ptr  <= g_idx;
              err_ovf <= 1'b1;
              state   <= IDLE;
            end
          end else if (!g_vld) begin
            // stalled-by-backpressure cycles leave tmo_cnt untouched
            if (tmo_cnt == TIMEOUT - 16'd1) begin
              gnt     <= 3'b000;
              rr_ptr  <= g_idx;
              err_tmo <= 1'b1;
              state   <= IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_arb.sv
// tb/tb_tx_frame_arb.sv - scoreboard bench for tx_frame_arb
`timescale 1ns/1ps
module tb_tx_frame_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [2:0]  vld = 3'b000;
  logic [2:0]  last = 3'b000;
  logic [7:0]  din0 = 8'd0, din1 = 8'd0, din2 = 8'd0;
  logic [2:0]  ack, gnt;
  logic        wen;
  logic [7:0]  wdata;
  logic        full = 1'b0;
  logic [4:0]  usedw = 5'd0;
  logic [15:0] frm_cnt;
  logic        err_ovf, err_tmo;

  always #5 clk = ~clk;

  tx_frame_arb dut (
    .clk(clk), .rst(rst), .ena(ena), .req(req), .vld(vld), .last(last),
    .din0(din0), .din1(din1), .din2(din2), .ack(ack), .gnt(gnt),
    .tx_fifo_wen(wen), .tx_fifo_wdata(wdata), .tx_fifo_full(full),
    .tx_fifo_usedw(usedw), .frm_cnt(frm_cnt), .err_ovf(err_ovf), .err_tmo(err_tmo)
  );

  int n_chk = 0, n_fail = 0;
  int n_wen = 0, n_ovf = 0, n_tmo = 0, n_cyc = 0, wen_cyc = 0, tmo_cyc = 0;
  logic [7:0] exp_q[$];
  logic [2:0] exp_gnt[$];
  logic [8:0] sq0[$], sq1[$], sq2[$];
  logic [2:0] fired = 3'b000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic int qsize(input int i);
    case (i)
      0: return sq0.size();
      1: return sq1.size();
      default: return sq2.size();
    endcase
  endfunction

  function automatic logic [8:0] qhead(input int i);
    case (i)
      0: return sq0[0];
      1: return sq1[0];
      default: return sq2[0];
    endcase
  endfunction

  task automatic qpop(input int i);
    if (qsize(i) > 0) begin
      case (i)
        0: void'(sq0.pop_front());
        1: void'(sq1.pop_front());
        default: void'(sq2.pop_front());
      endcase
    end
  endtask

  // producers: present queued bytes at negedge, note transfers just before posedge
  initial begin
    logic [8:0] h;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (fired[i]) qpop(i);
        req[i] = qsize(i) > 0;
        vld[i] = qsize(i) > 0;
        h = (qsize(i) > 0) ? qhead(i) : 9'h000;
        last[i] = h[8];
        case (i)
          0: din0 = h[7:0];
          1: din1 = h[7:0];
          default: din2 = h[7:0];
        endcase
      end
      #4 fired = rst ? (vld & ack) : 3'b000;
    end
  end

  // monitor: pops the scoreboard whenever the FIFO write strobe or a new grant appears
  initial begin
    logic [2:0] prev_gnt;
    prev_gnt = 3'b000;
    forever begin
      @(negedge clk);
      if (rst) begin
        n_cyc++;
        if (wen) begin
          n_wen++;
          wen_cyc = n_cyc;
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_write: got %0h expected none", wdata);
          end else begin
            check("fifo_wdata", {24'd0, wdata}, {24'd0, exp_q.pop_front()});
          end
        end
        if (err_ovf) n_ovf++;
        if (err_tmo) begin
          n_tmo++;
          tmo_cyc = n_cyc;
        end
        if (gnt != 3'b000 && prev_gnt == 3'b000) begin
          if (exp_gnt.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_grant: got %0h expected none", gnt);
          end else begin
            check("grant_order", {29'd0, gnt}, {29'd0, exp_gnt.pop_front()});
          end
        end
        prev_gnt = gnt;
      end else begin
        prev_gnt = 3'b000;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  function automatic int cur(input int which);
    case (which)
      0: return n_wen;
      1: return n_ovf;
      default: return n_tmo;
    endcase
  endfunction

  task automatic wait_for(input string name, input int which, input int target, input int budget);
    int k;
    k = 0;
    while (cur(which) < target && k < budget) begin
      tick(1);
      k++;
    end
    if (cur(which) < target) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: wait expired, got %0d expected %0d", name, cur(which), target);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, {29'd0, gnt}, 32'd0);
    check({tag, "_ack"}, {29'd0, ack}, 32'd0);
    check({tag, "_wen"}, {31'd0, wen}, 32'd0);
    check({tag, "_wdata"}, {24'd0, wdata}, 32'd0);
    check({tag, "_frm_cnt"}, {16'd0, frm_cnt}, 32'd0);
    check({tag, "_err_ovf"}, {31'd0, err_ovf}, 32'd0);
    check({tag, "_err_tmo"}, {31'd0, err_tmo}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(2);
    check_reset_outputs("reset");
    rst = 1'b1;
    tick(1);
  endtask

  initial begin
    int base;
    do_reset();

    // ena low blocks the grant, then a single 5-byte frame from requester 0
    ena = 1'b0;
    sq0 = '{9'h055, 9'h0AA, 9'h001, 9'h002, 9'h103};
    exp_q = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h03};
    exp_gnt.push_back(3'b001);
    base = n_wen;
    tick(5);
    check("ena_block_gnt", {29'd0, gnt}, 32'd0);
    ena = 1'b1;
    wait_for("single_writes", 0, base + 5, 50);
    tick(3);
    check("single_wen_count", n_wen - base, 5);
    check("single_gnt_idle", {29'd0, gnt}, 32'd0);
    check("single_frm_cnt", {16'd0, frm_cnt}, 32'd1);

    // round robin from reset: 0,1,2,0 with frames kept contiguous
    do_reset();
    sq0 = '{9'h0A0, 9'h0A1, 9'h1A2, 9'h0A3, 9'h0A4, 9'h1A5};
    sq1 = '{9'h0B0, 9'h0B1, 9'h1B2};
    sq2 = '{9'h0C0, 9'h0C1, 9'h1C2};
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2, 8'hC0, 8'hC1, 8'hC2, 8'hA3, 8'hA4, 8'hA5};
    exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001};
    base = n_wen;
    wait_for("rr_writes", 0, base + 12, 100);
    tick(3);
    check("rr_frm_cnt", {16'd0, frm_cnt}, 32'd4);
    check("rr_gnt_left", exp_gnt.size(), 0);
    check("rr_gnt_idle", {29'd0, gnt}, 32'd0);

    // backpressure: usedw at the almost-full level for 50 cycles mid-frame
    for (int k = 0; k < 10; k++) begin
      sq0.push_back({(k == 9) ? 1'b1 : 1'b0, 8'h10 + 8'(k)});
      exp_q.push_back(8'h10 + 8'(k));
    end
    exp_gnt.push_back(3'b001);
    base = n_wen;
    wait_for("bp_first", 0, base + 3, 50);
    usedw = 5'd30;
    begin
      int snap, bad;
      tick(1);
      snap = n_wen;
      bad = 0;
      repeat (49) begin
        tick(1);
        if (ack != 3'b000) bad++;
      end
      check("stall_wen", n_wen - snap, 0);
      check("stall_ack", bad, 0);
      check("stall_gnt_held", {29'd0, gnt}, 32'h1);
      check("stall_tmo", n_tmo, 0);
    end
    usedw = 5'd29;
    wait_for("bp_rest", 0, base + 10, 50);
    tick(3);
    check("bp_frm_cnt", {16'd0, frm_cnt}, 32'd5);
    check("bp_wen_count", n_wen - base, 10);

    // overflow: 250 bytes without last from requester 1, requester 2 pending
    for (int k = 0; k < 250; k++) begin
      sq1.push_back({1'b0, 8'(k)});
      if (k < 200) exp_q.push_back(8'(k));
    end
    sq2 = '{9'h0C8, 9'h1C9};
    exp_q.push_back(8'hC8);
    exp_q.push_back(8'hC9);
    exp_gnt = '{3'b010, 3'b100};
    base = n_wen;
    wait_for("ovf_pulse", 1, 1, 400);
    check("ovf_wen_count", n_wen - base, 200);
    sq1.delete();
    wait_for("ovf_next_frame", 0, base + 202, 50);
    tick(3);
    check("ovf_pulses", n_ovf, 1);
    check("ovf_frm_cnt", {16'd0, frm_cnt}, 32'd6);
    check("ovf_gnt_left", exp_gnt.size(), 0);

    // timeout: requester 2 sends one byte and goes quiet
    sq2 = '{9'h077};
    exp_q.push_back(8'h77);
    exp_gnt.push_back(3'b100);
    base = n_wen;
    wait_for("tmo_byte", 0, base + 1, 50);
    tick(100);
    check("tmo_gnt_held", {29'd0, gnt}, 32'h4);
    wait_for("tmo_pulse", 2, 1, 12000);
    check("tmo_gnt_released", {29'd0, gnt}, 32'd0);
    check("tmo_idle_cycles", tmo_cyc - wen_cyc, 11059);
    tick(3);
    check("tmo_pulses", n_tmo, 1);
    check("tmo_frm_cnt", {16'd0, frm_cnt}, 32'd6);
    check("tmo_exp_left", exp_q.size(), 0);

    // asynchronous reset in the middle of a streaming frame
    for (int k = 0; k < 8; k++) begin
      sq0.push_back({(k == 7) ? 1'b1 : 1'b0, 8'h30 + 8'(k)});
      exp_q.push_back(8'h30 + 8'(k));
    end
    exp_gnt.push_back(3'b001);
    base = n_wen;
    wait_for("arst_stream", 0, base + 3, 50);
    #1 rst = 1'b0;
    #1 check_reset_outputs("arst");
    sq0.delete();
    exp_q.delete();
    exp_gnt.delete();
    tick(2);
    rst = 1'b1;
    tick(3);
    check("arst_gnt_after", {29'd0, gnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_frame_arb.md
# tx_frame_arb

Frame-atomic round-robin arbiter that shares the single UART transmit FIFO (uart1 TX path, 8-bit data, 5-bit used-word count) among three frame producers: pulse-capture, analog-acquisition and status/version frames. The arbiter grants one requester at a time and forwards its bytes into the FIFO under FIFO flow control. A grant is never interrupted until that producer's frame ends, so frames from different producers are never interleaved on the wire. Watchdogs release a grant held by a stuck or runaway producer.

## Interface
- AFULL_LVL, 5'd30: stop accepting bytes when tx_fifo_usedw >= this value; gives headroom for in-flight writes.
- MAX_FRAME, 8'd200: maximum bytes per frame; a frame reaching this count without last is aborted.
- TIMEOUT, 16'd11059: granted-but-idle cycles before forced release (100 us at the 110.592 MHz system clock).
- clk  in  1  system clock (110.592 MHz domain, same clock as the UART FIFO write side).
- rst  in  1  asynchronous, active-low reset.
- ena  in  1  enable from init_ctrl done; low blocks new grants.
- req  in  3  per-requester frame request; level, held until the last byte is accepted.
- vld  in  3  per-requester byte valid.
- last  in  3  per-requester end-of-frame marker, qualified by vld.
- din0, din1, din2  in  8 each  requester byte data.
- ack  out  3  byte accepted; combinational; a byte transfers when vld[i] & ack[i].
- gnt  out  3  one-hot current grant, registered.
- tx_fifo_wen  out  1  FIFO write strobe, registered.
- tx_fifo_wdata  out  8  FIFO write data, registered.
- tx_fifo_full  in  1  FIFO full.
- tx_fifo_usedw  in  5  FIFO fill level.
- frm_cnt  out  16  completed-frame counter; wraps at 16'hFFFF -> 0.
- err_ovf  out  1  one-cycle pulse when a frame is aborted at MAX_FRAME.
- err_tmo  out  1  one-cycle pulse when a grant is released by the timeout.

## Operation
- The state machine has two states, IDLE and XFER. An rr_ptr[1:0] records the last-granted index; its reset value is 2, so requester 0 has first priority.
- IDLE:
  - If ena=1 and any req bit is set, grant the first set req scanning from rr_ptr+1 modulo 3.
  - Load gnt, clear byte_cnt and tmo_cnt, and go to XFER.
- XFER:
  - room = !tx_fifo_full && (tx_fifo_usedw < AFULL_LVL).
  - ack[g] = vld[g] & room, where g is the granted index. Every other ack bit is 0.
- Accepted byte: on the next edge, tx_fifo_wen=1, tx_fifo_wdata=din_g, byte_cnt is incremented, and tmo_cnt is cleared.
- Accepted byte with last[g]=1:
  - gnt is cleared, rr_ptr is set to g, and frm_cnt is incremented.
  - The state returns to IDLE.
- Accepted byte with last=0 that makes byte_cnt == MAX_FRAME:
  - The byte is still written.
  - gnt is cleared, rr_ptr is set to g, and err_ovf pulses.
  - The state returns to IDLE. frm_cnt does not increment.
  - The requester must drop req on its own; if req stays high, a new grant is allowed later under normal round-robin.
- Timeout: each XFER cycle with vld[g]=0 increments tmo_cnt. Cycles where vld[g]=1 but room=0 are backpressure: they neither count nor clear tmo_cnt. When tmo_cnt reaches TIMEOUT-1 and another idle cycle occurs:
  - gnt is cleared, rr_ptr is set to g, and err_tmo pulses.
  - The state returns to IDLE.
- ena going low during XFER has no effect on the current frame. It blocks only the next grant.
- req[g] dropping during XFER without last is not a release. Only last, the watchdogs or reset end a grant.
- A minimum of 1 IDLE cycle separates consecutive grants.

## Timing
- Reset values: gnt=0, ack=0, tx_fifo_wen=0, tx_fifo_wdata=0, frm_cnt=0, err_ovf=0, err_tmo=0, state=IDLE, rr_ptr=2.
- Reset is asynchronous: asserting rst mid-frame clears everything immediately. A partially written frame stays in the FIFO.
- Grant latency: req rises at cycle N, gnt is valid at N+1, and the first ack is possible at N+1.
- Write latency: a byte accepted at cycle k appears as tx_fifo_wen/wdata at k+1.
- Throughput: 1 byte/cycle while room=1.
- At most 2 writes are in flight beyond the usedw sample; AFULL_LVL <= 30 guarantees no write to a full FIFO.
- byte_cnt is 8 bits; tmo_cnt is 16 bits.

## Test plan
- Single requester: req0 with a 5-byte frame 0x55,0xAA,0x01,0x02,0x03 (last on 0x03) -> exactly 5 wen pulses with that data in order, gnt back to 0, frm_cnt=1.
- Round-robin: req0/1/2 all held for 3-byte frames from reset -> grant order 0,1,2,0 with no interleaving, and each frame contiguous in the FIFO.
- Backpressure: usedw driven to 30 mid-frame for 50 cycles -> ack=0 and no wen for the whole stall, no err_tmo, and the frame resumes intact when usedw drops to 29.
- Overflow: requester 1 sends 250 bytes with no last -> 200 writes, err_ovf pulses once at the 200th byte, and requester 2 pending is granted next.
- Timeout: requester 2 granted, sends 1 byte then holds vld=0 -> err_tmo after 11059 idle cycles and gnt cleared. Async rst asserted mid-frame -> all outputs return to reset values in the same cycle.
